// File: rtl/game_judge_if.sv
// Board-judge request/verdict bundle between the board controller and game_judge.
// Handshake: start is a request that the judge takes only while busy=0 (it
// is ignored otherwise, never queued); each accepted start yields exactly
// one done pulse. result/win_line/error hold until the next done.
interface game_judge_if;
  logic        start;
  logic [17:0] state;
  logic        busy;
  logic        done;
  logic [1:0]  result;
  logic [2:0]  win_line;
  logic        error;
  logic        dbg_fsm;

  modport master (
    output start, state,
    input  busy, done, result, win_line, error, dbg_fsm
  );

  modport slave (
    input  start, state,
    output busy, done, result, win_line, error, dbg_fsm
  );
endinterface

// File: rtl/game_judge.sv
// Tic-tac-toe verdict engine: snapshots the board on start, then checks one
// line per clock in fixed table order and reports the first win, draw or none.
module game_judge (
  input  logic         clk,
  input  logic         rst,
  game_judge_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [17:0] snap_q, snap_d;
  logic [2:0]  line_q, line_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  result_q, result_d;
  logic [2:0]  win_q, win_d;
  logic        error_q, error_d;

  logic [1:0]  cells [9];
  logic [3:0]  ia, ib, ic;
  logic        any_illegal, has_empty, line_win;

  always_comb begin
    any_illegal = 1'b0;
    has_empty   = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cells[i] = snap_q[2*i +: 2];
      if (bus.state[2*i +: 2] == 2'b11) any_illegal = 1'b1;
      if (snap_q[2*i +: 2] == 2'b00) has_empty = 1'b1;
    end
  end

  // Cell indices of the line under test, in evaluation order.
  always_comb begin
    ia = 4'd0; ib = 4'd1; ic = 4'd2;
    case (line_q)
      3'd0: begin ia = 4'd0; ib = 4'd1; ic = 4'd2; end
      3'd1: begin ia = 4'd3; ib = 4'd4; ic = 4'd5; end
      3'd2: begin ia = 4'd6; ib = 4'd7; ic = 4'd8; end
      3'd3: begin ia = 4'd0; ib = 4'd3; ic = 4'd6; end
      3'd4: begin ia = 4'd1; ib = 4'd4; ic = 4'd7; end
      3'd5: begin ia = 4'd2; ib = 4'd5; ic = 4'd8; end
      3'd6: begin ia = 4'd0; ib = 4'd4; ic = 4'd8; end
      default: begin ia = 4'd2; ib = 4'd4; ic = 4'd6; end
    endcase
  end

  assign line_win = (cells[ia] != 2'b00) && (cells[ia] == cells[ib]) &&
                    (cells[ib] == cells[ic]);

  always_comb begin
    fsm_d    = fsm_q;
    snap_d   = snap_q;
    line_d   = line_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    win_d    = win_q;
    error_d  = error_q;
    case (fsm_q)
      IDLE: begin
        if (bus.start) begin
          snap_d = bus.state;
          line_d = 3'd0;
          if (any_illegal) begin
            done_d   = 1'b1;
            error_d  = 1'b1;
            result_d = 2'b00;
            win_d    = 3'd0;
          end else begin
            fsm_d  = SCAN;
            busy_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (line_win) begin
          result_d = cells[ia];
          win_d    = line_q;
          error_d  = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          fsm_d    = IDLE;
        end else if (line_q == 3'd7) begin
          // Last line checked without a win: full board is a draw.
          result_d = has_empty ? 2'b00 : 2'b11;
          win_d    = 3'd0;
          error_d  = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          fsm_d    = IDLE;
        end else begin
          line_d = line_q + 3'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= IDLE;
      snap_q   <= 18'd0;
      line_q   <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 2'b00;
      win_q    <= 3'd0;
      error_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      snap_q   <= snap_d;
      line_q   <= line_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      win_q    <= win_d;
      error_q  <= error_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.win_line = win_q;
  assign bus.error    = error_q;
  assign bus.dbg_fsm  = fsm_q;
endmodule

// File: doc/game_judge.md
GAME_JUDGE -- requirements
Module: game_judge

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset (one clock; reset is synchronous and active-high); all state updates on the rising edge of clk.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to evaluate the board; sampled only in IDLE.
REQ-005 state  input  18  board from the board-state register; cell i (0..8, row-major) at bits [2i+1:2i]; 00 empty, 01 X, 10 O, 11 illegal.
REQ-006 busy  output  1  high while a scan is in progress.
REQ-007 done  output  1  one-cycle pulse marking a new verdict.
REQ-008 result  output  2  00 in progress, 01 X wins, 10 O wins, 11 draw.
REQ-009 win_line  output  3  index of the winning line; 0 when result is not a win.
REQ-010 error  output  1  snapshot contained an 11 cell.

Function
REQ-011 SHALL implement FSM states IDLE and SCAN; all outputs registered.
REQ-012 Line table, evaluated in this order: 0:(0,1,2) 1:(3,4,5) 2:(6,7,8) 3:(0,3,6) 4:(1,4,7) 5:(2,5,8) 6:(0,4,8) 7:(2,4,6).
REQ-013 IDLE, start=1 at edge E0: latch state into an 18-bit snapshot and clear the 3-bit line counter to 0.
- If any snapshot cell = 11: stay IDLE; done=1, error=1, result=00, win_line=0 in the cycle after E0.
- Otherwise: go to SCAN with busy=1.
REQ-014 SCAN: one line per edge; line k is evaluated at edge E(k+1) using the snapshot only.
- Later changes on state SHALL be ignored until the next accepted start.
REQ-015 Win on line k: all three cells equal and nonzero.
- At edge E(k+1), set result to the cell value, win_line=k, error=0, done=1, busy=0, and return to IDLE.
- Remaining lines SHALL NOT be checked; the first match in table order wins.
REQ-016 No win after line 7, at edge E8:
- result=11 if no cell is 00, else 00.
- win_line=0, error=0, done=1, busy=0; return to IDLE.
REQ-017 Latency: win on line k is seen k+1 cycles after start; no-win verdict 8 cycles after start; illegal-cell verdict 1 cycle after start.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 result, win_line and error SHALL hold their values from the last verdict until the next verdict.
- done=0 does not invalidate them.
REQ-020 start while busy=1 SHALL be ignored: no restart, no queuing, no extra done.
REQ-021 start in the cycle where done=1 SHALL be accepted, since the FSM is already in IDLE.
REQ-022 Line counter SHALL NOT wrap: SCAN always exits at line 7 or earlier.

Reset
REQ-023 On rst=1 at an edge: state=IDLE, busy=0, done=0, result=00, win_line=0, error=0, snapshot=0, counter=0.
REQ-024 rst SHALL take priority over start and over any SCAN decision in the same edge.
REQ-025 rst mid-scan SHALL abort the scan with no done pulse; outputs hold reset values until the next verdict.

Verification
REQ-026 state=18'h00015 (X on 0,1,2), start pulse -> busy 1 cycle; done 1 cycle after start; result=01, win_line=0, error=0.
REQ-027 state=18'h02220 (O on 2,4,6), start -> busy for 8 cycles; done 8 cycles after start; result=10, win_line=7.
REQ-028 state=18'h16A59 (XOX/XOO/OXX), start -> done 8 cycles after start; result=11, win_line=0. Then state=0, start -> result=00 after 8 cycles.
REQ-029 state=18'h00300 (cell 4 = 11), start -> done the next cycle; error=1, result=00, busy never 1.
REQ-030 Start with 18'h02220, then:
- change state to 18'h00015 and pulse start during SCAN -> ignored; single done with result=10.
- rerun and assert rst at cycle 3 of SCAN -> no done; all outputs at reset values.
REQ-031 Start asserted in the done cycle of REQ-026 with state=18'h00015 -> second done exactly 2 cycles after the first; result=01.
